sync_pulse_scheduler: RTL and testbench
=======================================

Name: sync_pulse_scheduler

Overview:
- Shares one clkin→clkout pulse-synchronizer channel between pN_REQ event requesters, all in the source clock domain.
- Latches each request as a pending flag and picks one pending flag at a time by round-robin.
- Issues a single-cycle launch pulse with a channel id. After each launch, enforces a hold-off so the synchronizer's loop-back clear completes before the next pulse.
- Counts requests lost to a still-pending duplicate.

Parameters:
- pN_REQ, 4: number of requesters; legal range 2..16.
- pGAP, 16: hold-off cycles after each launch; must be at least the synchronizer round-trip (pLENGTH+3); legal range 2..255.
- pCNT_W, 8: width of the drop counter.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  launches permitted when high.
- req  in  pN_REQ  per-requester event strobe; each high cycle is one event.
- drop_clr  in  1  synchronous clear of drop_cnt.
- pend  out  pN_REQ  registered pending flags.
- sync_pulse  out  1  registered one-cycle launch strobe; connects to synchronizer sin.
- sync_id  out  ID_W  registered id of the launched requester; ID_W = max(1, clog2(pN_REQ)); held until the next launch.
- busy  out  1  high when the FSM is not in IDLE.
- drop_cnt  out  pCNT_W  saturating count of dropped events.

Behaviour:
- Reset values: pend=0, sync_pulse=0, sync_id=0, busy=0, drop_cnt=0, rr pointer=0, FSM=IDLE, hold-off counter=0.
- Pending flags:
  - pend[k] is set one cycle after req[k].
  - In the cycle pend[k] is being cleared by a launch, a req[k] in that same cycle wins: pend[k] stays 1 and no drop is counted.
  - A req[k] while pend[k]=1 and k is not being launched counts as a drop; pend is unchanged.
- FSM states:
  - IDLE: if enable=1 and pend≠0, choose grant = first set bit of pend searching from the rr pointer upward, modulo pN_REQ; go to LAUNCH.
  - LAUNCH (one cycle): sync_pulse=1; sync_id=grant; clear pend[grant]; pointer ← (grant+1) mod pN_REQ; load counter with pGAP-1; go to HOLDOFF.
  - HOLDOFF: counter decrements each cycle; at 0 go to IDLE. Duration is exactly pGAP cycles. enable is ignored here.
- Latency: req[k] at cycle t with the FSM idle and enabled gives pend at t+1 and sync_pulse at t+2.
- Back-to-back launches: with requests continuously pending, sync_pulse rising edges are exactly pGAP+2 cycles apart.
- The grant is captured in IDLE and does not change if pend changes during LAUNCH.
- enable deasserted: a launch already in progress (LAUNCH/HOLDOFF) completes; the FSM then parks in IDLE while pend keeps accumulating.
- drop_cnt:
  - Adds the popcount of dropping bits in a cycle.
  - Saturates at all-ones.
  - If drop_clr and drops occur in the same cycle, drop_cnt = that cycle's drop popcount, saturated.
- Reset mid-operation: any in-flight LAUNCH or HOLDOFF is abandoned immediately; sync_pulse goes low asynchronously.

Optional Feature:
- Macro SYNC_SCHED_PRIO0_EN.
- Defined: in IDLE, requester 0 has strict priority. It is granted whenever pend[0]=1, and the rr pointer is left unchanged when 0 is granted. The remaining requesters use round-robin as above.
- Undefined: pure round-robin for all requesters.

Decomposition:
- Package sync_sched_pkg holds:
  - the state typedef sched_state_t {IDLE, LAUNCH, HOLDOFF};
  - a clog2-based function computing ID_W;
  - the constant SCHED_GAP_MIN = 2.
- One combinational sub-module rr_pick: inputs the pend mask and pointer; outputs grant id and a valid flag; parameterized by pN_REQ.
- FSM, pending flags and drop counter live in the top module.

Test Plan:
- Single event: reset released, enable=1, req=4'b0100 for 1 cycle at t → pend[2] at t+1; sync_pulse=1, sync_id=2 at t+2; busy high t+2..t+2+pGAP; drop_cnt=0.
- Round-robin fairness: req=4'b1111 held 1 cycle → launches with ids 0,1,2,3 in order, spaced 18 cycles (pGAP=16); pend empties after the 4th launch.
- Drop counting: req[1] pulsed 3 times while pend[1]=1 and enable=0 → drop_cnt=2. drop_clr alone → 0. With pCNT_W=2, 5 drops → 3 (saturated).
- Set-wins collision: req[3] asserted exactly in the LAUNCH cycle for id 3 → pend[3] stays 1; a second launch with id 3 follows after 18 cycles; drop_cnt unchanged.
- Enable/reset mid-op: enable→0 during HOLDOFF → no further pulses, pend retained; enable→1 → next launch within 2 cycles. Reset asserted in HOLDOFF → all outputs 0 immediately; pointer restarts at 0.
- With SYNC_SCHED_PRIO0_EN: req=4'b1110 pending, req[0] arrives during HOLDOFF → next launch has id 0, then round-robin resumes at id 1.

Source files
------------

// File: rtl/sync_sched_pkg.sv
// ----------------------------------------------------------------------------
// sync_sched_pkg
// Purpose : shared types and helpers for the pulse-synchronizer scheduler.
// Contents: sched_state_t  - scheduler FSM state encoding
//           calc_id_w()    - width of a requester id, never below 1 bit
//           SCHED_GAP_MIN  - smallest legal hold-off length
// ----------------------------------------------------------------------------
package sync_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        HOLDOFF = 2'd2
    } sched_state_t;

    localparam int SCHED_GAP_MIN = 2;

    function automatic int calc_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_pulse_scheduler_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Purpose : combinational round-robin picker. Returns the first set bit of
//           the pending mask, searching upward from the pointer and wrapping
//           modulo pN_REQ.
// Ports   : i_pend  [pN_REQ-1:0] pending mask
//           i_ptr   [ID_W-1:0]   search start position
//           o_grant [ID_W-1:0]   chosen requester (0 when nothing pending)
//           o_valid              at least one pending bit exists
// ----------------------------------------------------------------------------
module rr_pick
    import sync_sched_pkg::*;
#(
    parameter int pN_REQ = 4,
    parameter int ID_W   = calc_id_w(pN_REQ)
) (
    input  logic [pN_REQ-1:0] i_pend,
    input  logic [ID_W-1:0]   i_ptr,
    output logic [ID_W-1:0]   o_grant,
    output logic              o_valid
);

    always_comb begin
        int unsigned       idx;
        logic [pN_REQ-1:0] shifted;
        o_grant = '0;
        o_valid = 1'b0;
        idx     = 0;
        shifted = '0;
        for (int i = 0; i < pN_REQ; i++) begin
            idx     = (int'(i_ptr) + i) % pN_REQ;
            shifted = i_pend >> idx;
            if (!o_valid && shifted[0]) begin
                o_valid = 1'b1;
                o_grant = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sync_pulse_scheduler.sv
// ----------------------------------------------------------------------------
// sync_pulse_scheduler
// Purpose : shares one pulse-synchronizer channel between pN_REQ requesters.
//           Requests are latched as pending flags, one is granted at a time
//           (round-robin), a one-cycle launch pulse with the requester id is
//           issued, and a hold-off of pGAP cycles follows each launch so the
//           synchronizer loop-back clear can finish. Requests that hit an
//           already-pending flag are counted as drops.
// Option  : SYNC_SCHED_PRIO0_EN - requester 0 gets strict priority and its
//           grants leave the round-robin pointer untouched.
// Ports   : i_clk            clock, all logic on posedge
//           i_reset          asynchronous active-high reset
//           i_enable         launches permitted when high (sampled in IDLE)
//           i_req  [N-1:0]   per-requester event strobes
//           i_drop_clr       synchronous clear of o_drop_cnt
//           o_pend [N-1:0]   pending flags
//           o_sync_pulse     one-cycle launch strobe (to synchronizer sin)
//           o_sync_id        id of the launched requester, held
//           o_busy           FSM not in IDLE
//           o_drop_cnt       saturating dropped-event count
// ----------------------------------------------------------------------------
// state   | meaning
// IDLE    | waiting for enable and a pending request; grant picked here
// LAUNCH  | one cycle, sync pulse high, granted flag cleared, pointer advanced
// HOLDOFF | pGAP cycles of quiet while the synchronizer clears
// ----------------------------------------------------------------------------
module sync_pulse_scheduler
    import sync_sched_pkg::*;
#(
    parameter int pN_REQ = 4,
    parameter int pGAP   = 16,
    parameter int pCNT_W = 8,
    localparam int ID_W  = calc_id_w(pN_REQ)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [pN_REQ-1:0] i_req,
    input  logic              i_drop_clr,
    output logic [pN_REQ-1:0] o_pend,
    output logic              o_sync_pulse,
    output logic [ID_W-1:0]   o_sync_id,
    output logic              o_busy,
    output logic [pCNT_W-1:0] o_drop_cnt
);

    localparam int SUM_W = pCNT_W + 5;

    if (pGAP < SCHED_GAP_MIN) begin : g_bad_gap
        $error("sync_pulse_scheduler: pGAP below minimum");
    end

    sched_state_t      r_state;
    sched_state_t      w_next;
    logic [pN_REQ-1:0] r_pend;
    logic [ID_W-1:0]   r_ptr;
    logic [7:0]        r_cnt;
    logic              r_sync_pulse;
    logic [ID_W-1:0]   r_sync_id;
    logic [pCNT_W-1:0] r_drop_cnt;

    logic [ID_W-1:0]   w_rr_grant;
    logic              w_rr_valid;
    logic [ID_W-1:0]   w_sel_grant;
    logic [pN_REQ-1:0] w_clr;
    logic [pN_REQ-1:0] w_drop;
    logic [SUM_W-1:0]  w_pop;
    logic [SUM_W-1:0]  w_sum;
    logic [pCNT_W-1:0] w_drop_next;

    rr_pick #(
        .pN_REQ (pN_REQ),
        .ID_W   (ID_W)
    ) u_rr_pick (
        .i_pend  (r_pend),
        .i_ptr   (r_ptr),
        .o_grant (w_rr_grant),
        .o_valid (w_rr_valid)
    );

`ifdef SYNC_SCHED_PRIO0_EN
    assign w_sel_grant = r_pend[0] ? '0 : w_rr_grant;
`else
    assign w_sel_grant = w_rr_grant;
`endif

    // Granted flag is cleared at the end of LAUNCH; a same-cycle request
    // re-sets it, so it is neither lost nor counted as a drop.
    assign w_clr  = (r_state == LAUNCH) ? (pN_REQ'(1) << r_sync_id) : '0;
    assign w_drop = i_req & r_pend & ~w_clr;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < pN_REQ; i++) begin
            w_pop = w_pop + SUM_W'(w_drop[i]);
        end
        w_sum = (i_drop_clr ? '0 : SUM_W'(r_drop_cnt)) + w_pop;
        if (w_sum > SUM_W'({pCNT_W{1'b1}})) begin
            w_drop_next = '1;
        end else begin
            w_drop_next = w_sum[pCNT_W-1:0];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_enable && w_rr_valid) w_next = LAUNCH;
            LAUNCH:  w_next = HOLDOFF;
            HOLDOFF: if (r_cnt == 8'd0) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_pend       <= '0;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_sync_pulse <= 1'b0;
            r_sync_id    <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_state    <= w_next;
            r_pend     <= (r_pend & ~w_clr) | i_req;
            r_drop_cnt <= w_drop_next;

            // Grant is frozen into r_sync_id on entry to LAUNCH.
            if (r_state == IDLE && w_next == LAUNCH) begin
                r_sync_pulse <= 1'b1;
                r_sync_id    <= w_sel_grant;
            end else begin
                r_sync_pulse <= 1'b0;
            end

            if (r_state == LAUNCH) begin
                r_cnt <= 8'(pGAP - 1);
`ifdef SYNC_SCHED_PRIO0_EN
                if (r_sync_id != '0) begin
                    r_ptr <= (int'(r_sync_id) == pN_REQ - 1) ? '0 : r_sync_id + 1'b1;
                end
`else
                r_ptr <= (int'(r_sync_id) == pN_REQ - 1) ? '0 : r_sync_id + 1'b1;
`endif
            end else if (r_state == HOLDOFF && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    assign o_pend       = r_pend;
    assign o_sync_pulse = r_sync_pulse;
    assign o_sync_id    = r_sync_id;
    assign o_busy       = (r_state != IDLE);
    assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_sync_pulse_scheduler.sv
module tb_sync_pulse_scheduler;

    localparam int N   = 4;
    localparam int GAP = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] req;
    logic       drop_clr;
    logic [3:0] pend;
    logic       sync_pulse;
    logic [1:0] sync_id;
    logic       busy;
    logic [7:0] drop_cnt;

    logic       enable2;
    logic [3:0] req2;
    logic       drop_clr2;
    logic [3:0] pend2;
    logic       sync_pulse2;
    logic [1:0] sync_id2;
    logic       busy2;
    logic [1:0] drop_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sync_pulse_scheduler #(.pN_REQ(N), .pGAP(GAP), .pCNT_W(8)) u_dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_req(req),
        .i_drop_clr(drop_clr), .o_pend(pend), .o_sync_pulse(sync_pulse),
        .o_sync_id(sync_id), .o_busy(busy), .o_drop_cnt(drop_cnt)
    );

    sync_pulse_scheduler #(.pN_REQ(N), .pGAP(GAP), .pCNT_W(2)) u_sat (
        .i_clk(clk), .i_reset(reset), .i_enable(enable2), .i_req(req2),
        .i_drop_clr(drop_clr2), .o_pend(pend2), .o_sync_pulse(sync_pulse2),
        .o_sync_id(sync_id2), .o_busy(busy2), .o_drop_cnt(drop_cnt2)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; req = '0; drop_clr = 1'b0;
        enable2 = 1'b0; req2 = '0; drop_clr2 = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic wait_pulse(input int budget, output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < budget) begin
            step(1);
            cyc++;
            if (sync_pulse === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; req = 4'b1111; drop_clr = 1'b0;
        enable2 = 1'b0; req2 = '0; drop_clr2 = 1'b0;
        step(2);
        n_tests++; if (pend !== 4'b0000) begin n_fail++; $display("FAIL reset_pend got=%b exp=0000", pend); end
        n_tests++; if (sync_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got=%b exp=0", sync_pulse); end
        n_tests++; if (sync_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got=%0d exp=0", sync_id); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
        req = '0; enable = 1'b0; reset = 1'b0;
        step(1);
    endtask

    task automatic test_single_event();
        do_reset();
        enable = 1'b1;
        req = 4'b0100;
        step(1);
        req = '0;
        n_tests++; if (pend !== 4'b0100) begin n_fail++; $display("FAIL single_pend got=%b exp=0100", pend); end
        n_tests++; if (sync_pulse !== 1'b0) begin n_fail++; $display("FAIL single_early_pulse got=%b exp=0", sync_pulse); end
        step(1);
        n_tests++; if (sync_pulse !== 1'b1) begin n_fail++; $display("FAIL single_pulse got=%b exp=1", sync_pulse); end
        n_tests++; if (sync_id !== 2'd2) begin n_fail++; $display("FAIL single_id got=%0d exp=2", sync_id); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_launch got=%b exp=1", busy); end
        step(1);
        n_tests++; if (sync_pulse !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width got=%b exp=0", sync_pulse); end
        step(GAP - 1);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_last got=%b exp=1", busy); end
        step(1);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL single_drop got=%0d exp=0", drop_cnt); end
    endtask

    task automatic test_round_robin();
        int ids[4];
        int times[4];
        int n;
        n = 0;
        do_reset();
        enable = 1'b1;
        req = 4'b1111;
        step(1);
        req = '0;
        for (int c = 1; c <= 100 && n < 4; c++) begin
            step(1);
            if (sync_pulse === 1'b1) begin
                ids[n] = int'(sync_id);
                times[n] = c;
                n++;
            end
        end
        n_tests++;
        if (n != 4) begin
            n_fail++; $display("FAIL rr_count got=%0d exp=4", n);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_tests++; if (ids[k] != k) begin n_fail++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", k, ids[k], k); end
            end
            for (int k = 1; k < 4; k++) begin
                n_tests++; if (times[k] - times[k-1] != GAP + 2) begin n_fail++; $display("FAIL rr_gap[%0d] got=%0d exp=%0d", k, times[k] - times[k-1], GAP + 2); end
            end
        end
        step(1);
        n_tests++; if (pend !== 4'b0000) begin n_fail++; $display("FAIL rr_pend_empty got=%b exp=0000", pend); end
    endtask

    task automatic test_drop();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req = 4'b0010;
            step(1);
            req = '0;
            step(1);
        end
        n_tests++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL drop_cnt got=%0d exp=2", drop_cnt); end
        n_tests++; if (pend !== 4'b0010) begin n_fail++; $display("FAIL drop_pend got=%b exp=0010", pend); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy got=%b exp=0", busy); end
        drop_clr = 1'b1;
        step(1);
        drop_clr = 1'b0;
        n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL drop_clr got=%0d exp=0", drop_cnt); end
        drop_clr = 1'b1;
        req = 4'b0010;
        step(1);
        drop_clr = 1'b0;
        req = '0;
        n_tests++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL drop_clr_and_drop got=%0d exp=1", drop_cnt); end
        req2 = 4'b1111;
        step(1);
        req2 = 4'b0011;
        step(1);
        n_tests++; if (drop_cnt2 !== 2'd2) begin n_fail++; $display("FAIL sat_two got=%0d exp=2", drop_cnt2); end
        req2 = 4'b0111;
        step(1);
        n_tests++; if (drop_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_five got=%0d exp=3", drop_cnt2); end
        req2 = '0;
        step(1);
        n_tests++; if (drop_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_hold got=%0d exp=3", drop_cnt2); end
    endtask

    task automatic test_collision();
        int cyc;
        bit got;
        do_reset();
        enable = 1'b1;
        req = 4'b1000;
        step(1);
        req = '0;
        step(1);
        n_tests++; if (sync_pulse !== 1'b1 || sync_id !== 2'd3) begin n_fail++; $display("FAIL coll_launch got=%b/%0d exp=1/3", sync_pulse, sync_id); end
        req = 4'b1000;
        step(1);
        req = '0;
        n_tests++; if (pend !== 4'b1000) begin n_fail++; $display("FAIL coll_pend got=%b exp=1000", pend); end
        n_tests++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL coll_drop got=%0d exp=0", drop_cnt); end
        wait_pulse(40, cyc, got);
        n_tests++; if (!got || cyc != GAP + 1) begin n_fail++; $display("FAIL coll_relaunch got=%0d/%0d exp=1/%0d", got, cyc, GAP + 1); end
        n_tests++; if (sync_id !== 2'd3) begin n_fail++; $display("FAIL coll_id got=%0d exp=3", sync_id); end
    endtask

    task automatic test_enable_reset();
        int cyc;
        int pulses;
        bit got;
        do_reset();
        enable = 1'b1;
        req = 4'b0011;
        step(1);
        req = '0;
        step(1);
        n_tests++; if (sync_pulse !== 1'b1 || sync_id !== 2'd0) begin n_fail++; $display("FAIL en_first got=%b/%0d exp=1/0", sync_pulse, sync_id); end
        step(3);
        enable = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            step(1);
            if (sync_pulse === 1'b1) pulses++;
        end
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL en_off_pulses got=%0d exp=0", pulses); end
        n_tests++; if (pend !== 4'b0010) begin n_fail++; $display("FAIL en_off_pend got=%b exp=0010", pend); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_off_busy got=%b exp=0", busy); end
        enable = 1'b1;
        wait_pulse(2, cyc, got);
        n_tests++; if (!got || sync_id !== 2'd1) begin n_fail++; $display("FAIL en_resume got=%0d/%0d exp=1/1", got, sync_id); end

        do_reset();
        enable = 1'b1;
        req = 4'b0100;
        step(1);
        req = 4'b1000;
        step(1);
        req = '0;
        step(3);
        n_tests++; if (busy !== 1'b1 || sync_id !== 2'd2) begin n_fail++; $display("FAIL rst_pre got=%b/%0d exp=1/2", busy, sync_id); end
        reset = 1'b1;
        #1;
        n_tests++; if (sync_pulse !== 1'b0 || sync_id !== 2'd0 || busy !== 1'b0 || pend !== 4'b0000 || drop_cnt !== 8'd0)
            begin n_fail++; $display("FAIL rst_async got=%b/%0d/%b/%b/%0d exp=0/0/0/0000/0", sync_pulse, sync_id, busy, pend, drop_cnt); end
        step(1);
        reset = 1'b0;
        req = 4'b1111;
        step(1);
        req = '0;
        wait_pulse(5, cyc, got);
        n_tests++; if (!got || sync_id !== 2'd0) begin n_fail++; $display("FAIL rst_ptr got=%0d/%0d exp=1/0", got, sync_id); end
    endtask

`ifdef SYNC_SCHED_PRIO0_EN
    task automatic test_prio0();
        int cyc;
        bit got;
        do_reset();
        enable = 1'b1;
        req = 4'b0001;
        step(1);
        req = '0;
        step(1);
        n_tests++; if (sync_pulse !== 1'b1 || sync_id !== 2'd0) begin n_fail++; $display("FAIL prio_first got=%b/%0d exp=1/0", sync_pulse, sync_id); end
        step(2);
        req = 4'b1110;
        step(1);
        req = '0;
        step(2);
        req = 4'b0001;
        step(1);
        req = '0;
        for (int k = 0; k < 4; k++) begin
            wait_pulse(40, cyc, got);
            n_tests++; if (!got || int'(sync_id) != k) begin n_fail++; $display("FAIL prio_seq[%0d] got=%0d/%0d exp=1/%0d", k, got, sync_id, k); end
        end
    endtask
`endif

    initial begin
        reset = 1'b1; enable = 1'b0; req = '0; drop_clr = 1'b0;
        enable2 = 1'b0; req2 = '0; drop_clr2 = 1'b0;
        test_reset();
        test_single_event();
        test_round_robin();
        test_drop();
        test_collision();
        test_enable_reset();
`ifdef SYNC_SCHED_PRIO0_EN
        test_prio0();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
